// File: rtl/compfifo_gbe_dump.sv
// Reads one comparator-triad capture from the 48-bit FIFO and frames it as a 16-bit GbE word stream.
// Optional checksum trailer word enabled with `define COMPDUMP_CSUM_EN.
module compfifo_gbe_dump #(
    parameter int TRIAD_WORDS = 9,
    parameter int N_PAD       = 4,
    parameter int FIBER_ID    = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic        fabric_clk,
    input  logic        reset,
    input  logic        compfifo_dav,
    input  logic [47:0] compfifo_dout,
    output logic        en_fiforead,
    input  logic        tx_ready,
    output logic [15:0] tx_dat,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy,
    output logic [15:0] pkt_count,
    output logic [15:0] trunc_count
);

    localparam int          WCW      = $clog2(TRIAD_WORDS + 1);
    localparam logic [15:0] HDR_WORD = {8'hCA, 4'h0, 4'(FIBER_ID)};
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0]  PAD_LAST = 4'(N_PAD - 1);
    localparam logic [WCW-1:0] WD_LAST = WCW'(TRIAD_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAD,
        S_HDR,
        S_FETCH,
        S_LATCH,
        S_SEND,
`ifdef COMPDUMP_CSUM_EN
        S_CSUM,
`endif
        S_TRL
    } state_t;

    state_t         state, state_n;
    logic [3:0]     pad_cnt;
    logic [1:0]     slot;
    logic [3:0]     words_read;
    logic [WCW-1:0] words_done;
    logic [7:0]     tmo_cnt;
    logic           trunc;
    logic [47:0]    shreg;
    logic           xfer;
    logic           last_word;
`ifdef COMPDUMP_CSUM_EN
    logic [15:0]    csum;
`endif

    assign xfer = tx_valid & tx_ready;
    assign busy = (state != S_IDLE);

`ifdef COMPDUMP_CSUM_EN
    assign last_word = (state == S_CSUM);
`else
    assign last_word = (state == S_TRL);
`endif

    always_ff @(posedge fabric_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Outputs depend only on registered state that advances on transfer, so they hold during stalls.
    always_comb begin
        state_n     = state;
        tx_valid    = 1'b0;
        tx_dat      = 16'h0000;
        tx_sof      = 1'b0;
        tx_eof      = 1'b0;
        en_fiforead = 1'b0;
        case (state)
            S_IDLE: if (compfifo_dav) state_n = S_PAD;
            S_PAD: begin
                tx_valid = 1'b1;
                tx_sof   = (pad_cnt == 4'd0);
                if (xfer && pad_cnt == PAD_LAST) state_n = S_HDR;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_dat   = HDR_WORD;
                if (xfer) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (compfifo_dav) begin
                    en_fiforead = 1'b1;
                    state_n     = S_LATCH;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = S_SEND;
                end
            end
            S_LATCH: state_n = S_SEND;
            S_SEND: begin
                tx_valid = 1'b1;
                tx_dat   = shreg[47:32];
                if (xfer && slot == 2'd2) begin
                    if (words_done == WD_LAST) state_n = S_TRL;
                    else if (trunc)            state_n = S_SEND;
                    else                       state_n = S_FETCH;
                end
            end
            S_TRL: begin
                tx_valid = 1'b1;
                tx_dat   = {trunc, 11'h000, words_read};
`ifdef COMPDUMP_CSUM_EN
                if (xfer) state_n = S_CSUM;
`else
                tx_eof = 1'b1;
                if (xfer) state_n = S_IDLE;
`endif
            end
`ifdef COMPDUMP_CSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_dat   = csum;
                tx_eof   = 1'b1;
                if (xfer) state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge fabric_clk) begin
        if (reset) begin
            pad_cnt     <= 4'd0;
            slot        <= 2'd0;
            words_read  <= 4'd0;
            words_done  <= '0;
            tmo_cnt     <= 8'd0;
            trunc       <= 1'b0;
            shreg       <= 48'd0;
            pkt_count   <= 16'd0;
            trunc_count <= 16'd0;
`ifdef COMPDUMP_CSUM_EN
            csum        <= 16'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    pad_cnt    <= 4'd0;
                    slot       <= 2'd0;
                    words_read <= 4'd0;
                    words_done <= '0;
                    tmo_cnt    <= 8'd0;
                    trunc      <= 1'b0;
`ifdef COMPDUMP_CSUM_EN
                    csum       <= 16'd0;
`endif
                end
                S_PAD: if (xfer) pad_cnt <= pad_cnt + 4'd1;
                S_FETCH: begin
                    if (compfifo_dav) begin
                        tmo_cnt <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (tmo_cnt == TMO_LAST) begin
                            trunc <= 1'b1;
                            shreg <= 48'd0;
                        end
                    end
                end
                S_LATCH: begin
                    shreg      <= compfifo_dout;
                    words_read <= words_read + 4'd1;
                end
                S_SEND: begin
                    if (xfer) begin
                        // After three shifts the register is zero, which is what a truncated word needs.
                        shreg <= {shreg[31:0], 16'h0000};
`ifdef COMPDUMP_CSUM_EN
                        csum  <= csum + shreg[47:32];
`endif
                        if (slot == 2'd2) begin
                            slot       <= 2'd0;
                            words_done <= words_done + WCW'(1);
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (xfer && last_word) begin
                pkt_count <= pkt_count + 16'd1;
                if (trunc) trunc_count <= trunc_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_compfifo_gbe_dump.sv
// Scoreboard bench for compfifo_gbe_dump: FIFO model, directed frames, back-pressure, underrun, reset.
module tb_compfifo_gbe_dump;

    localparam int TRIAD_WORDS = 9;
    localparam int N_PAD       = 4;
    localparam int FIBER_ID    = 0;
    localparam int TIMEOUT     = 255;
    localparam int DATA0       = N_PAD + 1;
`ifdef COMPDUMP_CSUM_EN
    localparam int FLEN = N_PAD + 1 + 3 * TRIAD_WORDS + 2;
`else
    localparam int FLEN = N_PAD + 1 + 3 * TRIAD_WORDS + 1;
`endif

    logic        fabric_clk = 1'b0;
    logic        reset;
    logic        compfifo_dav;
    logic [47:0] compfifo_dout;
    logic        en_fiforead;
    logic        tx_ready;
    logic [15:0] tx_dat;
    logic        tx_valid, tx_sof, tx_eof, busy;
    logic [15:0] pkt_count, trunc_count;

    compfifo_gbe_dump #(
        .TRIAD_WORDS(TRIAD_WORDS), .N_PAD(N_PAD), .FIBER_ID(FIBER_ID), .TIMEOUT(TIMEOUT)
    ) dut (
        .fabric_clk(fabric_clk), .reset(reset),
        .compfifo_dav(compfifo_dav), .compfifo_dout(compfifo_dout), .en_fiforead(en_fiforead),
        .tx_ready(tx_ready), .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .busy(busy), .pkt_count(pkt_count), .trunc_count(trunc_count)
    );

    always #5 fabric_clk = ~fabric_clk;

    logic [47:0] fifo_q[$];
    logic [17:0] exp_q[$];
    int          xfer_cyc[$];
    int          tests = 0, errs = 0;
    int          cyc = 0, n_reads = 0, n_xfer = 0;
    int          last_eof_cyc = -100, sof_gap = -1;
    int          rdy_mode = 0, rdy_phase = 0;
    bit          held_v = 1'b0;
    logic [17:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: observe at negedge, then update FIFO model and tx_ready just after posedge.
    task automatic cycle();
        logic        rd;
        logic [17:0] o, e;
        @(negedge fabric_clk);
        cyc++;
        o = {tx_sof, tx_eof, tx_dat};
        if (held_v) chk("stall_hold", 32'({tx_valid, o}), 32'({1'b1, held}));
        rd = en_fiforead;
        if (rd === 1'b1) begin
            n_reads++;
            chk("rd_with_dav", 32'(compfifo_dav), 32'd1);
            chk("rd_while_stalled", 32'(held_v), 32'd0);
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            n_xfer++;
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                chk("word", 32'(o), 32'(e));
            end
            if (tx_sof) sof_gap = cyc - last_eof_cyc;
            if (tx_eof) last_eof_cyc = cyc;
        end
        held_v = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        held   = o;
        @(posedge fabric_clk);
        #1;
        if (rd === 1'b1 && fifo_q.size() > 0) compfifo_dout = fifo_q.pop_front();
        compfifo_dav = (fifo_q.size() != 0);
        if (rdy_mode == 0) tx_ready = 1'b1;
        else begin
            tx_ready  = (rdy_phase == 0);
            rdy_phase = (rdy_phase + 1) % 3;
        end
    endtask

    function automatic logic [47:0] data_word(input int base, input int i, input bit ones);
        return ones ? 48'h0001_0001_0001 : 48'h0000_1111_0000 + 48'(base + i);
    endfunction

    task automatic load(input int base, input int n, input bit ones);
        for (int i = 0; i < n; i++) fifo_q.push_back(data_word(base, i, ones));
        compfifo_dav = (fifo_q.size() != 0);
    endtask

    task automatic push_frame(input int base, input int nreal, input bit ones);
        logic [47:0] w;
        logic [15:0] d, trl;
        logic [15:0] sum = 16'd0;
        for (int p = 0; p < N_PAD; p++) exp_q.push_back({(p == 0), 1'b0, 16'h0000});
        exp_q.push_back({2'b00, 8'hCA, 4'h0, 4'(FIBER_ID)});
        for (int i = 0; i < TRIAD_WORDS; i++) begin
            w = (i < nreal) ? data_word(base, i, ones) : 48'd0;
            for (int s = 0; s < 3; s++) begin
                d   = w[47 - 16 * s -: 16];
                sum = sum + d;
                exp_q.push_back({2'b00, d});
            end
        end
        trl = {(nreal < TRIAD_WORDS), 11'h000, 4'(nreal)};
`ifdef COMPDUMP_CSUM_EN
        exp_q.push_back({2'b00, trl});
        exp_q.push_back({2'b01, sum});
`else
        exp_q.push_back({2'b01, trl});
`endif
    endtask

    task automatic run_frames(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_in_budget", 32'(exp_q.size()), 32'd0);
        chk("idle_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        fifo_q.delete();
        compfifo_dav = 1'b0;
        reset = 1'b1;
        cycle();
        reset  = 1'b0;
        held_v = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        reset = 1'b1; compfifo_dav = 1'b0; compfifo_dout = 48'd0; tx_ready = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_dat", 32'(tx_dat), 32'd0);
        chk("rst_sof_eof", 32'({tx_sof, tx_eof}), 32'd0);
        chk("rst_en_fiforead", 32'(en_fiforead), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_counts", 32'({pkt_count, trunc_count}), 32'd0);

        // Normal frame
        n_reads = 0; xfer_cyc.delete();
        load(0, TRIAD_WORDS, 1'b0); push_frame(0, TRIAD_WORDS, 1'b0);
        run_frames(500);
        chk("norm_len", 32'(xfer_cyc.size()), 32'(FLEN));
        chk("norm_reads", 32'(n_reads), 32'(TRIAD_WORDS));
        chk("norm_pkt", 32'(pkt_count), 32'd1);

        // Back-pressure 1-0-0
        rdy_mode = 1; rdy_phase = 0; n_reads = 0; xfer_cyc.delete();
        load(0, TRIAD_WORDS, 1'b0); push_frame(0, TRIAD_WORDS, 1'b0);
        run_frames(1500);
        rdy_mode = 0; tx_ready = 1'b1;
        chk("bp_len", 32'(xfer_cyc.size()), 32'(FLEN));
        chk("bp_reads", 32'(n_reads), 32'(TRIAD_WORDS));
        chk("bp_pkt", 32'(pkt_count), 32'd2);

        // Underrun: 4 words then timeout
        n_reads = 0; xfer_cyc.delete();
        load(0, 4, 1'b0); push_frame(0, 4, 1'b0);
        run_frames(3000);
        chk("ur_reads", 32'(n_reads), 32'd4);
        chk("ur_trunc_count", 32'(trunc_count), 32'd1);
        chk("ur_pkt", 32'(pkt_count), 32'd3);
        if (xfer_cyc.size() > DATA0 + 12)
            chk("ur_timeout_gap", 32'(xfer_cyc[DATA0 + 12] - xfer_cyc[DATA0 + 11]), 32'(TIMEOUT + 1));
        else
            chk("ur_xfer_count", 32'(xfer_cyc.size()), 32'(FLEN));

        // Reset during SEND of word 5
        n_xfer = 0;
        load(0, TRIAD_WORDS, 1'b0); push_frame(0, TRIAD_WORDS, 1'b0);
        n = 0;
        while (n_xfer < DATA0 + 13 && n < 300) begin cycle(); n++; end
        chk("mid_reached_word5", 32'(n_xfer), 32'(DATA0 + 13));
        do_reset();
        chk("mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_counts", 32'({pkt_count, trunc_count}), 32'd0);
        chk("mid_en_fiforead", 32'(en_fiforead), 32'd0);
        n_reads = 0; xfer_cyc.delete();
        load(0, TRIAD_WORDS, 1'b0); push_frame(0, TRIAD_WORDS, 1'b0);
        run_frames(500);
        chk("fresh_len", 32'(xfer_cyc.size()), 32'(FLEN));
        chk("fresh_reads", 32'(n_reads), 32'(TRIAD_WORDS));
        chk("fresh_pkt", 32'(pkt_count), 32'd1);

        // Back-to-back frames from 18 preloaded words
        do_reset();
        n_reads = 0; xfer_cyc.delete(); last_eof_cyc = -100; sof_gap = -1;
        load(0, 2 * TRIAD_WORDS, 1'b0);
        push_frame(0, TRIAD_WORDS, 1'b0); push_frame(TRIAD_WORDS, TRIAD_WORDS, 1'b0);
        run_frames(1000);
        chk("b2b_len", 32'(xfer_cyc.size()), 32'(2 * FLEN));
        chk("b2b_reads", 32'(n_reads), 32'(2 * TRIAD_WORDS));
        chk("b2b_pkt", 32'(pkt_count), 32'd2);
        chk("b2b_sof_gap_le2", 32'(sof_gap <= 2 && sof_gap >= 1), 32'd1);

`ifdef COMPDUMP_CSUM_EN
        // All-ones data: checksum of 27 words is 16'h001B
        xfer_cyc.delete();
        load(0, TRIAD_WORDS, 1'b1); push_frame(0, TRIAD_WORDS, 1'b1);
        chk("csum_model", 32'(exp_q[exp_q.size() - 1]), 32'({2'b01, 16'h001B}));
        run_frames(500);
        chk("csum_len", 32'(xfer_cyc.size()), 32'd34);
        chk("csum_pkt", 32'(pkt_count), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
